mine_controller: RTL and testbench
==================================

Name: mine_controller

Overview:
Sequences the lifecycle of one mine object on the game board: placement, arming, armed wait, explosion and cooldown. It latches the mine's grid-snapped position and drives the mine bitmap's bomb_exist/bomb_exploded inputs and the mine square's top-left coordinates. Timing is counted in video frames using the startOfFrame tick, so durations are independent of the pixel clock. It sits between game logic (player place request, collision detection) and the mine drawing path.

Parameters:
ARM_FRAMES, 60, frames from placement until the mine becomes triggerable (must be >=1)
LIFETIME_FRAMES, 240, frames in ARMED before automatic detonation (must be >=1)
EXPLODE_FRAMES, 30, frames the explosion is displayed (must be >=1)
COOLDOWN_FRAMES, 20, frames after explosion before a new placement is accepted (must be >=1)
CNT_W, 8, frame counter width; every *_FRAMES value must be <= 2^CNT_W

Ports:
clk  input  1  system clock
resetN  input  1  synchronous active-low reset
startOfFrame  input  1  one-cycle pulse per video frame
place_req  input  1  level request to place a mine
place_x  input  11  requested pixel X (player position)
place_y  input  11  requested pixel Y
trigger  input  1  collision of a player with the mine square
place_ack  output  1  one-cycle pulse: placement accepted
topLeftX  output  11  mine top-left X, low 5 bits zero
topLeftY  output  11  mine top-left Y, low 5 bits zero
bomb_exist  output  1  mine graphic should be drawn
bomb_exploded  output  1  explosion graphic active
explode_pulse  output  1  one-cycle pulse on entry to EXPLODE
explode_cause  output  1  0 = timeout, 1 = trigger; valid with explode_pulse, held until next explosion
busy  output  1  state != IDLE

Behaviour:
- Reset (resetN=0 at rising clk): state IDLE, counter 0, all outputs 0 (topLeftX/Y=0, explode_cause=0). Reset mid-operation aborts immediately to IDLE; no explode_pulse is generated.
- All outputs registered; state-derived outputs change the cycle after the state register.
- States: IDLE, ARMING, ARMED, EXPLODE, COOLDOWN.
- Counter: cleared to 0 on entry to every timed state; increments on each startOfFrame cycle. A timed state with duration N is left on the startOfFrame cycle at which the counter equals N-1, i.e. on the Nth frame tick after entry.
- IDLE: if place_req=1 then in that cycle latch topLeftX={place_x[10:5],5'b0}, topLeftY={place_y[10:5],5'b0}, pulse place_ack for exactly one cycle, go to ARMING. place_req in any other state is ignored (no ack, position unchanged).
- ARMING: bomb_exist=1. trigger ignored. After ARM_FRAMES ticks -> ARMED.
- ARMED: bomb_exist=1. trigger=1 -> EXPLODE with cause=1. LIFETIME_FRAMES ticks elapsed -> EXPLODE with cause=0. If trigger and the final timeout tick occur in the same cycle, cause=1 and only one explosion occurs.
- EXPLODE: bomb_exist=1, bomb_exploded=1. explode_pulse high the first cycle of EXPLODE only. trigger ignored. After EXPLODE_FRAMES ticks -> COOLDOWN.
- COOLDOWN: bomb_exist=0, bomb_exploded=0, place_req ignored. After COOLDOWN_FRAMES ticks -> IDLE.
- IDLE: bomb_exist=0, bomb_exploded=0. topLeftX/Y retain their last value.
- busy=1 in every state except IDLE.
- A startOfFrame arriving in the same cycle as a state entry does not count toward the new state; counting starts from the next tick.
- place_x/y >= 1024: the value is snapped the same way with no clamping; bounds checking is the game logic's responsibility.

Test Plan:
- Reset then idle: resetN=0 for 2 cycles, then 1 with no stimulus -> all outputs 0, busy=0 for 10 frames.
- Placement snap: place_req=1 with place_x=77, place_y=130 -> single-cycle place_ack, topLeftX=64, topLeftY=128, bomb_exist=1. A second place_req during ARMING -> no ack, position unchanged.
- Timeout path (ARM=2, LIFE=3, EXPLODE=2, COOL=2): place, then frame ticks only -> ARMED after 2 ticks; explode_pulse with cause=0 on the 3rd ARMED tick; bomb_exploded high for exactly 2 ticks; busy drops after 2 more ticks.
- Trigger path: trigger during ARMING -> ignored. Trigger 1 cycle after ARMED entry -> explode_pulse next cycle, explode_cause=1, bomb_exploded=1.
- Simultaneous trigger and final LIFETIME tick -> exactly one explode_pulse, explode_cause=1.
- Reset during EXPLODE -> next cycle IDLE, bomb_exploded=0, no explode_pulse. A new place_req is accepted right after resetN returns to 1.

Source files
------------

// File: rtl/mine_controller.sv
// mine_controller: frame-timed lifecycle sequencer for a single placeable mine
module mine_controller #(
  parameter int ARM_FRAMES      = 60,
  parameter int LIFETIME_FRAMES = 240,
  parameter int EXPLODE_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        place_req,
  input  logic [10:0] place_x,
  input  logic [10:0] place_y,
  input  logic        trigger,
  output logic        place_ack,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        bomb_exist,
  output logic        bomb_exploded,
  output logic        explode_pulse,
  output logic        explode_cause,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ARMING, ARMED, EXPLODE, COOLDOWN} state_t;
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIFE_LAST = CNT_W'(LIFETIME_FRAMES - 1);
  localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             done;
  // final frame tick of the current timed state
  always_comb begin
    last = state == ARMING ? ARM_LAST : state == ARMED ? LIFE_LAST :
           state == EXPLODE ? EXP_LAST : COOL_LAST;
    done = startOfFrame && cnt == last;
  end
  // lifecycle FSM; visual outputs follow the state register by one cycle
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= IDLE;
      cnt           <= '0;
      place_ack     <= 1'b0;
      topLeftX      <= '0;
      topLeftY      <= '0;
      bomb_exist    <= 1'b0;
      bomb_exploded <= 1'b0;
      explode_pulse <= 1'b0;
      explode_cause <= 1'b0;
      busy          <= 1'b0;
    end else begin
      place_ack     <= 1'b0;
      explode_pulse <= 1'b0;
      bomb_exist    <= state inside {ARMING, ARMED, EXPLODE};
      bomb_exploded <= state == EXPLODE;
      busy          <= state != IDLE;
      cnt           <= startOfFrame ? cnt + 1'b1 : cnt;
      case (state)
        IDLE: if (place_req) begin
          topLeftX  <= {place_x[10:5], 5'b0};
          topLeftY  <= {place_y[10:5], 5'b0};
          place_ack <= 1'b1;
          state     <= ARMING;
          cnt       <= '0;
        end
        ARMING: if (done) begin
          state <= ARMED;
          cnt   <= '0;
        end
        ARMED: if (trigger || done) begin
          state         <= EXPLODE;
          cnt           <= '0;
          explode_pulse <= 1'b1;
          explode_cause <= trigger;
        end
        EXPLODE: if (done) begin
          state <= COOLDOWN;
          cnt   <= '0;
        end
        COOLDOWN: if (done) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mine_controller.sv
// tb_mine_controller: directed checks of placement, timeout, trigger and reset paths
module tb_mine_controller;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        place_req = 1'b0;
  logic [10:0] place_x = '0;
  logic [10:0] place_y = '0;
  logic        trigger = 1'b0;
  logic        place_ack;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        bomb_exist;
  logic        bomb_exploded;
  logic        explode_pulse;
  logic        explode_cause;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  mine_controller #(
    .ARM_FRAMES(2), .LIFETIME_FRAMES(3), .EXPLODE_FRAMES(2), .COOLDOWN_FRAMES(2), .CNT_W(8)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .place_req(place_req),
    .place_x(place_x), .place_y(place_y), .trigger(trigger), .place_ack(place_ack),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .bomb_exist(bomb_exist),
    .bomb_exploded(bomb_exploded), .explode_pulse(explode_pulse),
    .explode_cause(explode_cause), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic tick;
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask
  task automatic frame(input int n);
    repeat (n) begin
      tick();
      cyc();
    end
  endtask
  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_ack", place_ack, 0);
    chk("rst_x", topLeftX, 0);
    chk("rst_y", topLeftY, 0);
    chk("rst_exist", bomb_exist, 0);
    chk("rst_exploded", bomb_exploded, 0);
    chk("rst_pulse", explode_pulse, 0);
    chk("rst_cause", explode_cause, 0);
    chk("rst_busy", busy, 0);
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame(1);
      chk("idle_busy", busy, 0);
      chk("idle_exist", bomb_exist, 0);
    end
    place_req = 1'b1; place_x = 11'd77; place_y = 11'd130;
    cyc();
    place_req = 1'b0;
    chk("place_ack", place_ack, 1);
    chk("place_x", topLeftX, 64);
    chk("place_y", topLeftY, 128);
    cyc();
    chk("place_ack_once", place_ack, 0);
    chk("place_exist", bomb_exist, 1);
    chk("place_busy", busy, 1);
    place_req = 1'b1; place_x = 11'd500; place_y = 11'd600;
    cyc();
    place_req = 1'b0;
    chk("arming_noack", place_ack, 0);
    chk("arming_x", topLeftX, 64);
    chk("arming_y", topLeftY, 128);
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    cyc();
    cyc();
    chk("arming_trig_pulse", explode_pulse, 0);
    chk("arming_trig_exploded", bomb_exploded, 0);
    tick();
    cyc();
    tick();
    cyc();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    chk("trig_pulse", explode_pulse, 1);
    chk("trig_cause", explode_cause, 1);
    cyc();
    chk("trig_pulse_once", explode_pulse, 0);
    chk("trig_exploded", bomb_exploded, 1);
    chk("trig_exist", bomb_exist, 1);
    frame(2);
    frame(2);
    chk("trig_done_busy", busy, 0);
    chk("trig_done_exist", bomb_exist, 0);
    place_req = 1'b1; place_x = 11'd200; place_y = 11'd100;
    cyc();
    place_req = 1'b0;
    chk("to_ack", place_ack, 1);
    chk("to_x", topLeftX, 192);
    chk("to_y", topLeftY, 96);
    cyc();
    frame(1);
    tick();
    cyc();
    frame(2);
    chk("to_early_pulse", explode_pulse, 0);
    chk("to_early_exploded", bomb_exploded, 0);
    tick();
    chk("to_pulse", explode_pulse, 1);
    chk("to_cause", explode_cause, 0);
    cyc();
    chk("to_pulse_once", explode_pulse, 0);
    chk("to_exploded1", bomb_exploded, 1);
    cyc();
    tick();
    chk("to_exploded2", bomb_exploded, 1);
    cyc();
    tick();
    chk("to_exploded_last", bomb_exploded, 1);
    cyc();
    chk("cool_exploded", bomb_exploded, 0);
    chk("cool_exist", bomb_exist, 0);
    chk("cool_busy", busy, 1);
    place_req = 1'b1; place_x = 11'd900;
    cyc();
    place_req = 1'b0;
    chk("cool_noack", place_ack, 0);
    chk("cool_x", topLeftX, 192);
    tick();
    cyc();
    tick();
    chk("cool_busy_last", busy, 1);
    cyc();
    chk("idle_busy_drop", busy, 0);
    chk("idle_keep_x", topLeftX, 192);
    chk("idle_keep_y", topLeftY, 96);
    place_req = 1'b1; place_x = 11'd1023; place_y = 11'd2047;
    cyc();
    place_req = 1'b0;
    chk("big_ack", place_ack, 1);
    chk("big_x", topLeftX, 992);
    chk("big_y", topLeftY, 2016);
    cyc();
    frame(2);
    frame(2);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("sim_pulse", explode_pulse, 1);
    chk("sim_cause", explode_cause, 1);
    cyc();
    chk("sim_pulse_once", explode_pulse, 0);
    chk("sim_exploded", bomb_exploded, 1);
    cyc();
    chk("sim_no_second", explode_pulse, 0);
    resetN = 1'b0;
    cyc();
    resetN = 1'b1;
    chk("mid_rst_exploded", bomb_exploded, 0);
    chk("mid_rst_exist", bomb_exist, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulse", explode_pulse, 0);
    chk("mid_rst_x", topLeftX, 0);
    chk("mid_rst_cause", explode_cause, 0);
    cyc();
    chk("mid_rst_pulse2", explode_pulse, 0);
    place_req = 1'b1; place_x = 11'd64; place_y = 11'd64;
    cyc();
    place_req = 1'b0;
    chk("post_rst_ack", place_ack, 1);
    chk("post_rst_x", topLeftX, 64);
    chk("post_rst_y", topLeftY, 64);
    cyc();
    chk("post_rst_exist", bomb_exist, 1);
    chk("post_rst_busy", busy, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
